// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and request/ack instruction fetcher that waits for execute and
// then picks the next PC from jr, jump and branch controls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        isJmp,
    input  logic        isJr,
    input  logic [1:0]  brSel,
    input  logic [25:0] jumpAddr,
    input  logic [15:0] imm,
    input  logic [31:0] rs_val,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {BOOT, FETCH, VALID} state_t;
    state_t state, state_nx;
    logic taken;
    logic [31:0] br_target, next_pc;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= BOOT;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = FETCH;
            FETCH:   state_nx = imem_ack ? VALID : FETCH;
            VALID:   state_nx = exec_done ? FETCH : VALID;
            default: state_nx = BOOT;
        endcase
    end

    // Outputs decode the state register only, so reset drops them without waiting for a clock.
    always_comb begin
        imem_req    = state == FETCH;
        instr_valid = state == VALID;
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign taken     = (brSel == 2'd1 && alu_zero) || (brSel == 2'd2 && !alu_zero);
    assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign next_pc   = isJr  ? rs_val & 32'hFFFF_FFFC :
                       isJmp ? {pc_plus4[31:28], jumpAddr, 2'b00} :
                       taken ? br_target : pc_plus4;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc      <= RESET_PC;
            instr   <= 32'd0;
            retired <= RETIRED_INIT;
        end else begin
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (state == VALID && exec_done) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
            end
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a phase-level model.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, imem_ack = 1'b0, exec_done = 1'b0;
    logic        isJmp = 1'b0, isJr = 1'b0, alu_zero = 1'b0;
    logic [1:0]  brSel = 2'd0;
    logic [25:0] jumpAddr = 26'd0;
    logic [15:0] imm = 16'd0;
    logic [31:0] imem_rdata = 32'd0, rs_val = 32'd0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;

    logic        w_rst_n = 1'b0, w_ack = 1'b0, w_done = 1'b0;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_retired;

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .isJmp(isJmp), .isJr(isJr), .brSel(brSel),
        .jumpAddr(jumpAddr), .imm(imm), .rs_val(rs_val), .alu_zero(alu_zero),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .RETIRED_INIT(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(32'd0), .instr(w_instr), .instr_valid(w_valid),
        .exec_done(w_done), .isJmp(1'b0), .isJr(1'b0), .brSel(2'd0),
        .jumpAddr(26'd0), .imm(16'd0), .rs_val(32'd0), .alu_zero(1'b0),
        .pc(w_pc), .pc_plus4(w_pc4), .retired(w_retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: phase 0 = boot, 1 = waiting for memory, 2 = holding an instruction.
    int          m_phase = 0;
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_ret = 32'd0;

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic jr, input logic jmp,
                                              input logic [1:0] bs, input logic z, input logic [15:0] im,
                                              input logic [25:0] ja, input logic [31:0] rs);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (jr) return rs & 32'hFFFF_FFFC;
        if (jmp) return {seq[31:28], ja, 2'b00};
        if ((bs == 2'd1 && z) || (bs == 2'd2 && !z)) return seq + 32'(int'($signed(im)) * 4);
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_pc    = 32'd0;
            m_instr = 32'd0;
            m_ret   = 32'd0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_phase = 2;
            end
        end else if (exec_done) begin
            m_pc    = model_npc(m_pc, isJr, isJmp, brSel, alu_zero, imm, jumpAddr, rs_val);
            m_ret   = m_ret + 32'd1;
            m_phase = 1;
        end
    end

    always @(negedge clk)
        if (chk_en) begin
            chk("imem_req", imem_req, 32'(m_phase == 1));
            chk("instr_valid", instr_valid, 32'(m_phase == 2));
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("retired", retired, m_ret);
        end

    // Starts and ends at a negedge in the holding phase.
    task automatic step(input string name, input logic jr, input logic jmp, input logic [1:0] bs,
                        input logic z, input logic [15:0] im, input logic [25:0] ja,
                        input logic [31:0] rs, input logic [31:0] exp);
        isJr = jr; isJmp = jmp; brSel = bs; alu_zero = z; imm = im; jumpAddr = ja; rs_val = rs;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0; isJr = 1'b0; isJmp = 1'b0; brSel = 2'd0;
        chk(name, pc, exp);
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("model_rst_pc", m_pc, 32'd0);

        // Wrap-around of pc and retired on the second instance.
        w_rst_n = 1'b1;
        @(negedge clk);
        chk("wrap_req", w_req, 32'd1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'd0);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        chk("wrap_valid", w_valid, 32'd1);
        w_done = 1'b1;
        @(negedge clk);
        w_done = 1'b0;
        chk("wrap_pc", w_pc, 32'd0);
        chk("wrap_retired", w_retired, 32'd0);

        // Sequential run with immediate ack and exec_done.
        rst_n = 1'b1;
        imem_ack = 1'b1;
        exec_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_req", imem_req, 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * k));
            imem_rdata = $urandom;
            @(negedge clk);
            chk("seq_valid", instr_valid, 32'd1);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        exec_done = 1'b0;
        chk("seq_retired", retired, 32'd4);
        chk("model_seq_retired", m_ret, 32'd4);

        // Three wait cycles before the ack at pc 0x10.
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", imem_req, 32'd1);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_valid", instr_valid, 32'd0);
            if (i == 2) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("wait_instr", instr, 32'hDEAD_BEEF);
        chk("wait_valid_after", instr_valid, 32'd1);

        step("beq_taken", 0, 0, 2'd1, 1, 16'hFFFE, 26'd0, 32'd0, 32'h0C);
        step("jr_0x10", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'h10, 32'h10);
        step("beq_not_taken", 0, 0, 2'd1, 0, 16'hFFFE, 26'd0, 32'd0, 32'h14);
        step("jr_0x10", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'h10, 32'h10);
        step("bne_taken", 0, 0, 2'd2, 0, 16'hFFFE, 26'd0, 32'd0, 32'h0C);
        step("jr_0x10", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'h10, 32'h10);
        step("brsel3_none", 0, 0, 2'd3, 1, 16'hFFFE, 26'd0, 32'd0, 32'h14);
        step("jr_jmp_base", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'h1000_0040, 32'h1000_0040);
        step("jmp", 0, 1, 2'd0, 0, 16'd0, 26'h100, 32'd0, 32'h1000_0400);
        step("jr_align", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'h203, 32'h200);
        step("jr_priority", 1, 1, 2'd1, 1, 16'hFFFE, 26'h3FF_FFFF, 32'h300, 32'h300);
        step("jr_top", 1, 0, 2'd0, 0, 16'd0, 26'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        chk("top_pc4", pc_plus4, 32'd0);
        step("pc_wrap", 0, 0, 2'd0, 0, 16'd0, 26'd0, 32'd0, 32'd0);
        chk("model_pc_wrap", m_pc, 32'd0);

        // Reset between edges while a fetch is outstanding.
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("pre_rst_req", imem_req, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 32'd0);
        chk("async_rst_valid", instr_valid, 32'd0);
        chk("async_rst_pc", pc, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", imem_req, 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        imem_ack = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            imem_ack   = $urandom_range(0, 1) == 1;
            exec_done  = $urandom_range(0, 1) == 1;
            imem_rdata = $urandom;
            isJr       = $urandom_range(0, 7) == 0;
            isJmp      = $urandom_range(0, 7) == 0;
            brSel      = 2'($urandom_range(0, 3));
            alu_zero   = $urandom_range(0, 1) == 1;
            imm        = 16'($urandom);
            jumpAddr   = 26'($urandom);
            rs_val     = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_rst_req", imem_req, 32'd0);
                chk("rand_rst_valid", instr_valid, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
